// File: rtl/cpu_ctrl_pkg.sv
// State, opcode and bus encodings shared by the SRM control FSM, datapath and memory.
// Build option CTRL_HALT_EN adds the S_HALT state and the halt opcode.
package cpu_ctrl_pkg;

   typedef enum logic [4:0] {
      S_RESET_PC  = 5'd0,
      S_WAIT      = 5'd1,
      S_IF1       = 5'd2,
      S_IF2       = 5'd3,
      S_UPDATE_PC = 5'd4,
      S_DECODE    = 5'd5,
      S_MOV_IM    = 5'd6,
      S_GET_A     = 5'd7,
      S_GET_B     = 5'd8,
      S_ALU       = 5'd9,
      S_ALU_Z     = 5'd10,
      S_WRITE_RD  = 5'd11,
      S_STATUS    = 5'd12,
      S_ADD_IMM   = 5'd13,
      S_LOAD_ADDR = 5'd14,
      S_MEM_RD    = 5'd15,
      S_WRITE_LD  = 5'd16,
      S_GET_RD    = 5'd17,
      S_PASS_B    = 5'd18,
      S_MEM_WR    = 5'd19
`ifdef CTRL_HALT_EN
      , S_HALT    = 5'd20
`endif
   } state_e;

   localparam logic [2:0] OPC_MOV = 3'b110;
   localparam logic [2:0] OPC_ALU = 3'b101;
   localparam logic [2:0] OPC_LDR = 3'b011;
   localparam logic [2:0] OPC_STR = 3'b100;
`ifdef CTRL_HALT_EN
   localparam logic [2:0] OPC_HALT = 3'b111;
`endif

   localparam logic [1:0] OP_MOV_REG = 2'b00;
   localparam logic [1:0] OP_MOV_IMM = 2'b10;
   localparam logic [1:0] OP_ADD     = 2'b00;
   localparam logic [1:0] OP_CMP     = 2'b01;
   localparam logic [1:0] OP_AND     = 2'b10;
   localparam logic [1:0] OP_MVN     = 2'b11;
   localparam logic [1:0] OP_MEM     = 2'b00;

   localparam logic [1:0] VSEL_C     = 2'b00;
   localparam logic [1:0] VSEL_IMM   = 2'b01;
   localparam logic [1:0] VSEL_MDATA = 2'b11;

   localparam logic [1:0] MEM_NONE  = 2'b00;
   localparam logic [1:0] MEM_READ  = 2'b01;
   localparam logic [1:0] MEM_WRITE = 2'b10;

   localparam logic [2:0] NSEL_NONE = 3'b000;
   localparam logic [2:0] NSEL_RM   = 3'b001;
   localparam logic [2:0] NSEL_RD   = 3'b010;
   localparam logic [2:0] NSEL_RN   = 3'b100;

   typedef struct packed {
      logic [1:0] vsel;
      logic       write;
      logic       loada;
      logic       loadb;
      logic       asel;
      logic       bsel;
      logic       loadc;
      logic       loads;
      logic [2:0] nsel;
      logic       load_ir;
      logic       load_pc;
      logic       reset_pc;
      logic       load_addr;
      logic       addr_sel;
      logic [1:0] mem_cmd;
      logic       w;
   } ctrl_out_t;

   // States whose dwell time is stretched by the memory wait counter.
   function automatic logic is_mem_state(input state_e st);
      return (st == S_IF1) || (st == S_MEM_RD) || (st == S_MEM_WR);
   endfunction

endpackage

// File: rtl/ctrl_wait_counter.sv
// Loadable down-counter that stretches memory states; zero_o marks the final cycle.
module ctrl_wait_counter #(
   parameter int WAIT_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic [WAIT_W-1:0] load_val_i,
   input  logic              dec_i,
   output logic              zero_o
);

   localparam logic [WAIT_W-1:0] ONE = {{(WAIT_W-1){1'b0}}, 1'b1};

   logic [WAIT_W-1:0] cnt_q;
   logic [WAIT_W-1:0] cnt_d;

   // Load has priority; decrement saturates at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle SRM controller: fetch, PC update, decode, ALU ops and LDR/STR with memory wait states.
// Defining CTRL_HALT_EN makes opcode 111 enter a terminal halt state; otherwise it is a NOP.
module cpu_control_fsm
   import cpu_ctrl_pkg::*;
#(
   parameter int AUTO_RUN = 0,
   parameter int MEM_WAIT = 0,
   parameter int WAIT_W   = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       s,
   input  logic [2:0] opcode,
   input  logic [1:0] op,
   output logic [1:0] vsel,
   output logic       write,
   output logic       loada,
   output logic       loadb,
   output logic       asel,
   output logic       bsel,
   output logic       loadc,
   output logic       loads,
   output logic [2:0] nsel,
   output logic       load_ir,
   output logic       load_pc,
   output logic       reset_pc,
   output logic       load_addr,
   output logic       addr_sel,
   output logic [1:0] mem_cmd,
   output logic       w
);

   localparam state_e            END_STATE = (AUTO_RUN != 0) ? S_IF1 : S_WAIT;
   localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(MEM_WAIT);

   state_e    state_q;
   state_e    state_d;
   ctrl_out_t out_q;
   ctrl_out_t out_d;

   logic wait_zero_s;
   logic wait_load_s;
   logic wait_dec_s;
   logic is_mov_im_s;
   logic is_mov_reg_s;
   logic is_add_and_s;
   logic is_mvn_s;
   logic is_cmp_s;
   logic is_ldr_s;
   logic is_str_s;

   assign is_mov_im_s  = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
   assign is_mov_reg_s = (opcode == OPC_MOV) && (op == OP_MOV_REG);
   assign is_add_and_s = (opcode == OPC_ALU) && ((op == OP_ADD) || (op == OP_AND));
   assign is_mvn_s     = (opcode == OPC_ALU) && (op == OP_MVN);
   assign is_cmp_s     = (opcode == OPC_ALU) && (op == OP_CMP);
   assign is_ldr_s     = (opcode == OPC_LDR) && (op == OP_MEM);
   assign is_str_s     = (opcode == OPC_STR) && (op == OP_MEM);

   // The counter is reloaded only on entry, so a held memory state counts down once.
   assign wait_load_s = is_mem_state(state_d) && (state_d != state_q);
   assign wait_dec_s  = is_mem_state(state_q);

   ctrl_wait_counter #(
      .WAIT_W (WAIT_W)
   ) u_wait (
      .clk        (clk),
      .rst_n      (reset),
      .load_i     (wait_load_s),
      .load_val_i (WAIT_INIT),
      .dec_i      (wait_dec_s),
      .zero_o     (wait_zero_s)
   );

   function automatic ctrl_out_t decode_out(input state_e st);
      ctrl_out_t o;
      o         = '0;
      o.vsel    = VSEL_C;
      o.nsel    = NSEL_NONE;
      o.mem_cmd = MEM_NONE;
      case (st)
         S_RESET_PC:  begin o.reset_pc = 1'b1; o.load_pc = 1'b1; end
         S_WAIT:      o.w = 1'b1;
         S_IF1:       begin o.addr_sel = 1'b1; o.mem_cmd = MEM_READ; end
         S_IF2:       begin o.addr_sel = 1'b1; o.mem_cmd = MEM_READ; o.load_ir = 1'b1; end
         S_UPDATE_PC: o.load_pc = 1'b1;
         S_MOV_IM:    begin o.nsel = NSEL_RN; o.vsel = VSEL_IMM; o.write = 1'b1; end
         S_GET_A:     begin o.nsel = NSEL_RN; o.loada = 1'b1; end
         S_GET_B:     begin o.nsel = NSEL_RM; o.loadb = 1'b1; end
         S_ALU:       o.loadc = 1'b1;
         S_ALU_Z:     begin o.asel = 1'b1; o.loadc = 1'b1; end
         S_WRITE_RD:  begin o.nsel = NSEL_RD; o.vsel = VSEL_C; o.write = 1'b1; end
         S_STATUS:    o.loads = 1'b1;
         S_ADD_IMM:   begin o.bsel = 1'b1; o.loadc = 1'b1; end
         S_LOAD_ADDR: o.load_addr = 1'b1;
         S_MEM_RD:    o.mem_cmd = MEM_READ;
         S_WRITE_LD:  begin o.nsel = NSEL_RD; o.vsel = VSEL_MDATA; o.write = 1'b1; o.mem_cmd = MEM_READ; end
         S_GET_RD:    begin o.nsel = NSEL_RD; o.loadb = 1'b1; end
         S_PASS_B:    begin o.asel = 1'b1; o.loadc = 1'b1; end
         S_MEM_WR:    o.mem_cmd = MEM_WRITE;
`ifdef CTRL_HALT_EN
         S_HALT:      o.w = 1'b1;
`endif
         default:     o = '0;
      endcase
      return o;
   endfunction

   // Next-state logic; the IR fields are held stable for the whole instruction.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RESET_PC:  state_d = END_STATE;
         S_WAIT:      if (s) state_d = S_IF1; else state_d = S_WAIT;
         S_IF1:       if (wait_zero_s) state_d = S_IF2; else state_d = S_IF1;
         S_IF2:       state_d = S_UPDATE_PC;
         S_UPDATE_PC: state_d = S_DECODE;
         S_DECODE: begin
            if (is_mov_im_s)                     state_d = S_MOV_IM;
            else if (is_mov_reg_s || is_mvn_s)   state_d = S_GET_B;
            else if (is_add_and_s || is_cmp_s)   state_d = S_GET_A;
            else if (is_ldr_s || is_str_s)       state_d = S_GET_A;
`ifdef CTRL_HALT_EN
            else if (opcode == OPC_HALT)         state_d = S_HALT;
            else                                 state_d = END_STATE;
`else
            else                                 state_d = END_STATE;
`endif
         end
         S_GET_A: begin
            if (is_ldr_s || is_str_s)            state_d = S_ADD_IMM;
            else if (is_add_and_s || is_cmp_s)   state_d = S_GET_B;
            else                                 state_d = END_STATE;
         end
         S_GET_B: begin
            if (is_cmp_s)                        state_d = S_STATUS;
            else if (is_mvn_s || is_mov_reg_s)   state_d = S_ALU_Z;
            else if (is_add_and_s)               state_d = S_ALU;
            else                                 state_d = END_STATE;
         end
         S_ALU, S_ALU_Z: state_d = S_WRITE_RD;
         S_ADD_IMM:   state_d = S_LOAD_ADDR;
         S_LOAD_ADDR: begin
            if (is_ldr_s)                        state_d = S_MEM_RD;
            else if (is_str_s)                   state_d = S_GET_RD;
            else                                 state_d = END_STATE;
         end
         S_MEM_RD:    if (wait_zero_s) state_d = S_WRITE_LD; else state_d = S_MEM_RD;
         S_GET_RD:    state_d = S_PASS_B;
         S_PASS_B:    state_d = S_MEM_WR;
         S_MEM_WR:    if (wait_zero_s) state_d = END_STATE; else state_d = S_MEM_WR;
         S_MOV_IM, S_WRITE_RD, S_STATUS, S_WRITE_LD: state_d = END_STATE;
`ifdef CTRL_HALT_EN
         S_HALT:      state_d = S_HALT;
`endif
         default:     state_d = S_RESET_PC;
      endcase
      out_d = decode_out(state_d);
   end

   // State and Moore outputs registered together so outputs always match the current state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_RESET_PC;
         out_q   <= decode_out(S_RESET_PC);
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
      end
   end

   assign vsel      = out_q.vsel;
   assign write     = out_q.write;
   assign loada     = out_q.loada;
   assign loadb     = out_q.loadb;
   assign asel      = out_q.asel;
   assign bsel      = out_q.bsel;
   assign loadc     = out_q.loadc;
   assign loads     = out_q.loads;
   assign nsel      = out_q.nsel;
   assign load_ir   = out_q.load_ir;
   assign load_pc   = out_q.load_pc;
   assign reset_pc  = out_q.reset_pc;
   assign load_addr = out_q.load_addr;
   assign addr_sel  = out_q.addr_sel;
   assign mem_cmd   = out_q.mem_cmd;
   assign w         = out_q.w;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: four instances cover single-step, MEM_WAIT=3, MEM_WAIT=2 and free-run.
// Output vector layout: {vsel,write,loada,loadb,asel,bsel,loadc,loads,nsel,load_ir,load_pc,reset_pc,load_addr,addr_sel,mem_cmd,w}.
module tb_cpu_control_fsm;

   localparam logic [19:0] F_VSEL_IMM   = 20'h40000;
   localparam logic [19:0] F_VSEL_MDATA = 20'hC0000;
   localparam logic [19:0] F_WRITE      = 20'h20000;
   localparam logic [19:0] F_LOADA      = 20'h10000;
   localparam logic [19:0] F_LOADB      = 20'h08000;
   localparam logic [19:0] F_ASEL       = 20'h04000;
   localparam logic [19:0] F_BSEL       = 20'h02000;
   localparam logic [19:0] F_LOADC      = 20'h01000;
   localparam logic [19:0] F_LOADS      = 20'h00800;
   localparam logic [19:0] F_NSEL_RN    = 20'h00400;
   localparam logic [19:0] F_NSEL_RD    = 20'h00200;
   localparam logic [19:0] F_NSEL_RM    = 20'h00100;
   localparam logic [19:0] F_LOAD_IR    = 20'h00080;
   localparam logic [19:0] F_LOAD_PC    = 20'h00040;
   localparam logic [19:0] F_RESET_PC   = 20'h00020;
   localparam logic [19:0] F_LOAD_ADDR  = 20'h00010;
   localparam logic [19:0] F_ADDR_SEL   = 20'h00008;
   localparam logic [19:0] F_CMD_WRITE  = 20'h00004;
   localparam logic [19:0] F_CMD_READ   = 20'h00002;
   localparam logic [19:0] F_W          = 20'h00001;

   localparam logic [19:0] E_RST    = F_RESET_PC | F_LOAD_PC;
   localparam logic [19:0] E_WAIT   = F_W;
   localparam logic [19:0] E_IF1    = F_ADDR_SEL | F_CMD_READ;
   localparam logic [19:0] E_IF2    = F_ADDR_SEL | F_CMD_READ | F_LOAD_IR;
   localparam logic [19:0] E_UPD    = F_LOAD_PC;
   localparam logic [19:0] E_DEC    = 20'h00000;
   localparam logic [19:0] E_GETA   = F_NSEL_RN | F_LOADA;
   localparam logic [19:0] E_GETB   = F_NSEL_RM | F_LOADB;
   localparam logic [19:0] E_ALU    = F_LOADC;
   localparam logic [19:0] E_ALUZ   = F_ASEL | F_LOADC;
   localparam logic [19:0] E_WRRD   = F_NSEL_RD | F_WRITE;
   localparam logic [19:0] E_STAT   = F_LOADS;
   localparam logic [19:0] E_MOVIM  = F_NSEL_RN | F_VSEL_IMM | F_WRITE;
   localparam logic [19:0] E_ADDIMM = F_BSEL | F_LOADC;
   localparam logic [19:0] E_LDADDR = F_LOAD_ADDR;
   localparam logic [19:0] E_MEMRD  = F_CMD_READ;
   localparam logic [19:0] E_WRLD   = F_VSEL_MDATA | F_WRITE | F_NSEL_RD | F_CMD_READ;
   localparam logic [19:0] E_GETRD  = F_NSEL_RD | F_LOADB;
   localparam logic [19:0] E_PASSB  = F_ASEL | F_LOADC;
   localparam logic [19:0] E_MEMWR  = F_CMD_WRITE;

   logic       clk;
   logic       reset;
   logic       s;
   logic [2:0] opcode;
   logic [1:0] op;
   logic [19:0] obs [4];

   int checks;
   int errors;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      logic [1:0] vsel_w;
      logic [1:0] mem_cmd_w;
      logic [2:0] nsel_w;
      logic write_w, loada_w, loadb_w, asel_w, bsel_w, loadc_w, loads_w;
      logic load_ir_w, load_pc_w, reset_pc_w, load_addr_w, addr_sel_w, w_w;

      cpu_control_fsm #(
         .AUTO_RUN ((g == 3) ? 1 : 0),
         .MEM_WAIT ((g == 1) ? 3 : ((g == 2) ? 2 : 0)),
         .WAIT_W   (4)
      ) u_dut (
         .clk (clk), .reset (reset), .s (s), .opcode (opcode), .op (op),
         .vsel (vsel_w), .write (write_w), .loada (loada_w), .loadb (loadb_w),
         .asel (asel_w), .bsel (bsel_w), .loadc (loadc_w), .loads (loads_w),
         .nsel (nsel_w), .load_ir (load_ir_w), .load_pc (load_pc_w),
         .reset_pc (reset_pc_w), .load_addr (load_addr_w), .addr_sel (addr_sel_w),
         .mem_cmd (mem_cmd_w), .w (w_w)
      );

      assign obs[g] = {vsel_w, write_w, loada_w, loadb_w, asel_w, bsel_w, loadc_w, loads_w,
                       nsel_w, load_ir_w, load_pc_w, reset_pc_w, load_addr_w, addr_sel_w,
                       mem_cmd_w, w_w};
   end

   task automatic apply_reset();
      reset = 1'b0;
      s     = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic step();
      s = 1'b1;
      @(negedge clk);
      s = 1'b0;
   endtask

   task automatic test_reset();
      opcode = 3'b101;
      op     = 2'b00;
      reset  = 1'b0;
      s      = 1'b0;
      @(negedge clk);
      for (int g = 0; g < 4; g++) begin
         checks++;
         if (obs[g] !== E_RST) begin
            errors++;
            $display("FAIL reset_state inst%0d got=%05h exp=%05h", g, obs[g], E_RST);
         end
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (obs[3] !== E_IF1) begin
         errors++;
         $display("FAIL reset_autorun_to_if1 got=%05h exp=%05h", obs[3], E_IF1);
      end
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (obs[0] !== E_WAIT) begin
            errors++;
            $display("FAIL reset_wait_hold cyc%0d got=%05h exp=%05h", c, obs[0], E_WAIT);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_alu_ops();
      string       nm [10];
      logic [2:0]  opc [10];
      logic [1:0]  opv [10];
      int          hold [10];
      logic [19:0] tr [10][10];
      nm  = '{"add", "and_s_held", "cmp", "mvn", "mov_reg", "mov_imm", "nop_000", "nop_110_01", "ldr_w0", "str_w0"};
      opc = '{3'b101, 3'b101, 3'b101, 3'b101, 3'b110, 3'b110, 3'b000, 3'b110, 3'b011, 3'b100};
      opv = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00};
      hold = '{0, 7, 0, 0, 0, 0, 0, 0, 0, 0};
      tr[0] = '{E_IF1, E_IF2, E_UPD, E_DEC, E_GETA, E_GETB, E_ALU, E_WRRD, E_WAIT, E_WAIT};
      tr[1] = '{E_IF1, E_IF2, E_UPD, E_DEC, E_GETA, E_GETB, E_ALU, E_WRRD, E_WAIT, E_WAIT};
      tr[2] = '{E_IF1, E_IF2, E_UPD, E_DEC, E_GETA, E_GETB, E_STAT, E_WAIT, E_WAIT, E_WAIT};
      tr[3] = '{E_IF1, E_IF2, E_UPD, E_DEC, E_GETB, E_ALUZ, E_WRRD, E_WAIT, E_WAIT, E_WAIT};
      tr[4] = '{E_IF1, E_IF2, E_UPD, E_DEC, E_GETB, E_ALUZ, E_WRRD, E_WAIT, E_WAIT, E_WAIT};
      tr[5] = '{E_IF1, E_IF2, E_UPD, E_DEC, E_MOVIM, E_WAIT, E_WAIT, E_WAIT, E_WAIT, E_WAIT};
      tr[6] = '{E_IF1, E_IF2, E_UPD, E_DEC, E_WAIT, E_WAIT, E_WAIT, E_WAIT, E_WAIT, E_WAIT};
      tr[7] = '{E_IF1, E_IF2, E_UPD, E_DEC, E_WAIT, E_WAIT, E_WAIT, E_WAIT, E_WAIT, E_WAIT};
      tr[8] = '{E_IF1, E_IF2, E_UPD, E_DEC, E_GETA, E_ADDIMM, E_LDADDR, E_MEMRD, E_WRLD, E_WAIT};
      tr[9] = '{E_IF1, E_IF2, E_UPD, E_DEC, E_GETA, E_ADDIMM, E_LDADDR, E_GETRD, E_PASSB, E_MEMWR};
      apply_reset();
      for (int i = 0; i < 10; i++) begin
         opcode = opc[i];
         op     = opv[i];
         step();
         if (hold[i] != 0) s = 1'b1;
         for (int c = 0; c < 10; c++) begin
            checks++;
            if (obs[0] !== tr[i][c]) begin
               errors++;
               $display("FAIL %s cyc%0d got=%05h exp=%05h", nm[i], c, obs[0], tr[i][c]);
            end
            if (c == hold[i]) s = 1'b0;
            @(negedge clk);
         end
      end
   endtask

   task automatic test_ldr_wait3();
      logic [19:0] tr [$];
      tr = '{E_IF1, E_IF1, E_IF1, E_IF1, E_IF2, E_UPD, E_DEC, E_GETA, E_ADDIMM, E_LDADDR,
             E_MEMRD, E_MEMRD, E_MEMRD, E_MEMRD, E_WRLD, E_WAIT, E_WAIT};
      opcode = 3'b011;
      op     = 2'b00;
      apply_reset();
      step();
      foreach (tr[c]) begin
         checks++;
         if (obs[1] !== tr[c]) begin
            errors++;
            $display("FAIL ldr_wait3 cyc%0d got=%05h exp=%05h", c, obs[1], tr[c]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_str_wait2();
      logic [19:0] tr [$];
      tr = '{E_IF1, E_IF1, E_IF1, E_IF2, E_UPD, E_DEC, E_GETA, E_ADDIMM, E_LDADDR,
             E_GETRD, E_PASSB, E_MEMWR, E_MEMWR, E_MEMWR, E_WAIT, E_WAIT};
      opcode = 3'b100;
      op     = 2'b00;
      apply_reset();
      step();
      foreach (tr[c]) begin
         checks++;
         if (obs[2] !== tr[c]) begin
            errors++;
            $display("FAIL str_wait2 cyc%0d got=%05h exp=%05h", c, obs[2], tr[c]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      logic [19:0] tr [$];
      logic [19:0] post [$];
      bit          found;
      tr   = '{E_IF1, E_IF2, E_UPD, E_DEC, E_MOVIM, E_IF1, E_IF2, E_UPD, E_DEC, E_MOVIM, E_IF1};
      post = '{E_IF1, E_IF2, E_UPD, E_DEC, E_GETA};
      opcode = 3'b110;
      op     = 2'b10;
      apply_reset();
      foreach (tr[c]) begin
         checks++;
         if (obs[3] !== tr[c]) begin
            errors++;
            $display("FAIL autorun_loop cyc%0d got=%05h exp=%05h", c, obs[3], tr[c]);
         end
         @(negedge clk);
      end
      opcode = 3'b101;
      op     = 2'b00;
      found  = 1'b0;
      for (int c = 0; c < 12 && !found; c++) begin
         if (obs[3] === E_GETB) found = 1'b1;
         else @(negedge clk);
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL autorun_reach_getb got=%05h exp=%05h", obs[3], E_GETB);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (obs[3] !== E_RST) begin
         errors++;
         $display("FAIL abort_async got=%05h exp=%05h", obs[3], E_RST);
      end
      @(posedge clk);
      #1;
      checks++;
      if (obs[3] !== E_RST) begin
         errors++;
         $display("FAIL abort_next_edge got=%05h exp=%05h", obs[3], E_RST);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      foreach (post[c]) begin
         checks++;
         if (obs[3] !== post[c]) begin
            errors++;
            $display("FAIL abort_restart cyc%0d got=%05h exp=%05h", c, obs[3], post[c]);
         end
         @(negedge clk);
      end
   endtask

`ifdef CTRL_HALT_EN
   task automatic test_opcode_111();
      logic [19:0] tr [$];
      tr = '{E_IF1, E_IF2, E_UPD, E_DEC};
      opcode = 3'b111;
      op     = 2'b00;
      apply_reset();
      step();
      foreach (tr[c]) begin
         checks++;
         if (obs[0] !== tr[c]) begin
            errors++;
            $display("FAIL halt_fetch cyc%0d got=%05h exp=%05h", c, obs[0], tr[c]);
         end
         @(negedge clk);
      end
      for (int c = 0; c < 20; c++) begin
         checks++;
         if (obs[0] !== F_W) begin
            errors++;
            $display("FAIL halt_hold cyc%0d got=%05h exp=%05h", c, obs[0], F_W);
         end
         s = ~s;
         @(negedge clk);
      end
      apply_reset();
      checks++;
      if (obs[0] !== E_WAIT) begin
         errors++;
         $display("FAIL halt_exit_reset got=%05h exp=%05h", obs[0], E_WAIT);
      end
   endtask
`else
   task automatic test_opcode_111();
      logic [19:0] tr [$];
      tr = '{E_IF1, E_IF2, E_UPD, E_DEC, E_WAIT, E_WAIT};
      opcode = 3'b111;
      op     = 2'b11;
      apply_reset();
      step();
      foreach (tr[c]) begin
         checks++;
         if (obs[0] !== tr[c]) begin
            errors++;
            $display("FAIL nop_111 cyc%0d got=%05h exp=%05h", c, obs[0], tr[c]);
         end
         @(negedge clk);
      end
      step();
      checks++;
      if (obs[0] !== E_IF1) begin
         errors++;
         $display("FAIL nop_111_restep got=%05h exp=%05h", obs[0], E_IF1);
      end
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      s      = 1'b0;
      opcode = 3'b000;
      op     = 2'b00;
      test_reset();
      test_alu_ops();
      test_ldr_wait3();
      test_str_wait2();
      test_back_to_back();
      test_opcode_111();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

endmodule
